// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, the line
// terminator byte and a round-robin pick helper usable up to 16 requesters.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_ISSUE,
      ARB_WAIT_START,
      ARB_WAIT_DONE
   } arb_state_t;

   localparam byte UART_ARB_EOL = 8'h0A;

   // Widest request vector the pick helper handles.
   localparam int RR_MAX = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // First set bit of req[n-1:0], searching upward from (ptr+1) mod n
   // with wrap. n is a constant at every call site, so the modulo folds.
   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX-1:0] req,
      input logic [3:0]        ptr,
      input logic [4:0]        n
   );
      rr_pick_t   res;
      logic [3:0] k;
      res = '0;
      for (int i = 1; i <= RR_MAX; i++) begin
         k = 4'((32'(ptr) + 32'(i)) % 32'(n));
         if ((32'(i) <= 32'(n)) && !res.found && req[k]) begin
            res.found = 1'b1;
            res.idx   = k;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester above ptr_i wins.
// Ports: req_i/ptr_i in; onehot_o, idx_o, any_o out.
module rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] onehot_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   logic [RR_MAX-1:0] req_ext;
   rr_pick_t          pick;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req_i;
      pick = rr_pick(req_ext, 4'(ptr_i), 5'(NUM_REQ));
   end

   assign any_o    = pick.found;
   assign idx_o    = pick.idx[ID_W-1:0];
   assign onehot_o = pick.found ? (NUM_REQ'(1) << pick.idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams, one byte per
// grant, round-robin. Ports: clk, resetn (async, active low);
// req_valid/req_data in, req_ready one-hot pulse out; uart_transmit strobe,
// uart_tx_byte out, uart_is_transmitting in; grant_id, busy, timeout_err.
// Optional macro UART_ARB_LINE_LOCK_EN keeps a grantee until it sends 0x0A.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int  NUM_REQ       = 4,
   parameter int  START_TIMEOUT = 16,
`ifdef UART_ARB_LINE_LOCK_EN
   parameter int  LOCK_TIMEOUT  = 1024,
`endif
   localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 uart_transmit,
   output logic [7:0]           uart_tx_byte,
   input  logic                 uart_is_transmitting,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [7:0]         byte_q, byte_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               terr_q, terr_d;

   logic [NUM_REQ-1:0] req_eff;
   logic [NUM_REQ-1:0] win_oh;
   logic [ID_W-1:0]    win_idx;
   logic               win_any;
   logic [7:0]         win_byte;
   logic               grant;

`ifdef UART_ARB_LINE_LOCK_EN
   localparam int LCNT_W = $clog2(LOCK_TIMEOUT + 1);

   logic              lock_q, lock_d;
   logic [ID_W-1:0]   lock_id_q, lock_id_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;

   // While locked only the lock holder may compete.
   always_comb begin
      req_eff = req_valid;
      if (lock_q)
         req_eff = req_valid & (NUM_REQ'(1) << lock_id_q);
   end

   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      lcnt_d    = lcnt_q;
      if (grant) begin
         lock_d    = (win_byte != UART_ARB_EOL);
         lock_id_d = win_idx;
         lcnt_d    = '0;
      end else if (state_q == ARB_IDLE && lock_q) begin
         if (req_valid[lock_id_q]) begin
            lcnt_d = '0;
         end else begin
            lcnt_d = lcnt_q + 1'b1;
            if (lcnt_d == LCNT_W'(LOCK_TIMEOUT)) begin
               lock_d = 1'b0;
               lcnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         lcnt_q    <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         lcnt_q    <= lcnt_d;
      end
   end
`else
   always_comb req_eff = req_valid;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req_i    (req_eff),
      .ptr_i    (rr_ptr_q),
      .onehot_o (win_oh),
      .idx_o    (win_idx),
      .any_o    (win_any)
   );

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win_oh[i])
            win_byte = win_byte | req_data[8*i +: 8];
   end

   assign grant = (state_q == ARB_IDLE) && win_any
                  && !uart_is_transmitting;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      byte_d   = byte_q;
      ready_d  = '0;
      cnt_d    = cnt_q;
      terr_d   = terr_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (grant) begin
               ready_d  = win_oh;
               byte_d   = win_byte;
               grant_d  = win_idx;
               rr_ptr_d = win_idx;
               state_d  = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            cnt_d   = '0;
            state_d = ARB_WAIT_START;
         end
         ARB_WAIT_START: begin
            // Gives up after START_TIMEOUT full waiting cycles.
            if (uart_is_transmitting) begin
               state_d = ARB_WAIT_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(START_TIMEOUT)) begin
                  terr_d  = 1'b1;
                  state_d = ARB_IDLE;
               end
            end
         end
         ARB_WAIT_DONE: begin
            if (!uart_is_transmitting)
               state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
         grant_q  <= '0;
         byte_q   <= '0;
         ready_q  <= '0;
         cnt_q    <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         byte_q   <= byte_d;
         ready_q  <= ready_d;
         cnt_q    <= cnt_d;
         terr_q   <= terr_d;
      end
   end

   assign req_ready     = ready_q;
   assign uart_transmit = (state_q == ARB_ISSUE);
   assign uart_tx_byte  = byte_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q != ARB_IDLE);
   assign timeout_err   = terr_q;

endmodule
